step_seq_arb: RTL and testbench

STEP_SEQ_ARB -- requirements
Module: step_seq_arb

---
 rtl/step_seq_arb_pkg.sv | 18 +
 rtl/step_seq_arb_mod4.sv | 34 +++
 rtl/step_seq_arb.sv | 139 +++++++++++++
 tb/tb_step_seq_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_arb_pkg.sv
// Shared definitions for the step sequencer arbiter.
//   state_t  : controller FSM states (IDLE / RUN / DONE)
//   POS_W    : width of the modulo-4 position
//   STEP_W   : width of a requester's step count
//   PRESC_W  : width of the step prescaler (holds STEP_DIV-1, STEP_DIV <= 16)
package step_seq_arb_pkg;

    localparam int POS_W   = 2;
    localparam int STEP_W  = 4;
    localparam int PRESC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/step_seq_arb_mod4.sv
// mod4_updown: modulo-4 up/down position register.
//   clock : rising-edge clock
//   reset : synchronous, active-low; clears pos to 0
//   en    : advance one position this edge
//   up    : 1 = +1 (3 wraps to 0), 0 = -1 (0 wraps to 3)
//   pos   : current position
module mod4_updown
    import step_seq_arb_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    output logic [POS_W-1:0] pos
);

    logic [POS_W-1:0] pos_q, pos_d;

    // Wrap comes for free from the 2-bit arithmetic.
    always_comb begin
        pos_d = pos_q;
        if (en) begin
            pos_d = up ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) pos_q <= '0;
        else        pos_q <= pos_d;
    end

    assign pos = pos_q;

endmodule

// File: rtl/step_seq_arb.sv
// step_seq_arb: two-requester round-robin arbiter driving a stepped
// modulo-4 position. The winner's direction and step count are latched at
// grant; one step is executed every STEP_DIV cycles until the count is used.
//   clock      : rising-edge clock
//   reset      : synchronous, active-low
//   req[1:0]   : step requests, bit i = requester i
//   dir[1:0]   : per-requester direction, 1 = up, 0 = down
//   steps0/1   : step counts, sampled at grant
//   gnt[1:0]   : one-hot grant
//   busy       : FSM not IDLE
//   done[1:0]  : one-cycle completion pulse to the granted requester
//   step_pulse : one-cycle strobe per executed step (aligned with position)
//   position   : current modulo-4 position
// Build option: define STEP_ABORT_EN to abort a run when the granted
// requester drops its req (no done pulse, steps already taken are kept).
module step_seq_arb
    import step_seq_arb_pkg::*;
#(
    parameter int STEP_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        dir,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic [1:0]        done,
    output logic              step_pulse,
    output logic [POS_W-1:0]  position
);

    localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(STEP_DIV - 1);

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                last_q, last_d;    // index of most recently granted requester
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                step_q, step_d;

    logic win;
    logic any_req;
    logic abort;
    logic step_now;

    // Round-robin: on contention the requester not granted last wins.
    always_comb begin
        any_req = |req;
        if (req == 2'b11) win = ~last_q;
        else              win = req[1];
    end

`ifdef STEP_ABORT_EN
    assign abort = (state_q == RUN) && ((req & gnt_q) == 2'b00);
`else
    assign abort = 1'b0;
`endif

    // A zero latched count never steps; it just falls through to DONE.
    assign step_now = (state_q == RUN) && !abort && (rem_q != '0) && (presc_q == '0);

    // State register (and datapath flops)
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;   // so requester 0 takes the first contested grant
            dir_q   <= 1'b0;
            rem_q   <= '0;
            presc_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any_req) state_d = RUN;
            RUN: begin
                if (abort)                           state_d = IDLE;
                else if (rem_q == '0)                state_d = DONE;
                else if (step_now && rem_q == STEP_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, latch and prescaler updates
    always_comb begin
        gnt_d   = gnt_q;
        last_d  = last_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        // Registered so the strobe appears in the same cycle as the new position.
        step_d  = step_now;
        if (state_q == IDLE && any_req) begin
            gnt_d   = win ? 2'b10 : 2'b01;
            last_d  = win;
            dir_d   = dir[win];
            rem_d   = win ? steps1 : steps0;
            presc_d = PRESC_LOAD;
        end else if (state_q == RUN && !abort) begin
            presc_d = (presc_q == '0) ? PRESC_LOAD : (presc_q - PRESC_W'(1));
            if (step_now) rem_d = rem_q - STEP_W'(1);
        end
        if (state_d == IDLE) gnt_d = '0;
    end

    // Outputs
    always_comb begin
        gnt        = gnt_q;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE) ? gnt_q : 2'b00;
        step_pulse = step_q;
    end

    mod4_updown u_pos (
        .clock (clock),
        .reset (reset),
        .en    (step_now),
        .up    (dir_q),
        .pos   (position)
    );

endmodule

// File: tb/tb_step_seq_arb.sv
module tb_step_seq_arb;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] dir = '0;
    logic [3:0] steps0 = '0;
    logic [3:0] steps1 = '0;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] done;
    logic       step_pulse;
    logic [1:0] position;

    step_seq_arb #(.STEP_DIV(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .dir        (dir),
        .steps0     (steps0),
        .steps1     (steps1),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .step_pulse (step_pulse),
        .position   (position)
    );

    always #5 clock = ~clock;

    // kind: 0 = grant rise, 1 = step, 2 = done; dly = cycles since grant rose
    typedef struct {
        int kind;
        int val;
        int dly;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  gnt_cyc = 0;
    int  done_seen = 0;
    int  step_seen = 0;
    bit  mon_en = 0;
    int  pos_m = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int val, input int dly);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d dly=%0d, expected none", kind, val, dly);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val != val || e.dly != dly) begin
                errors++;
                $display("FAIL event_%0d: got kind=%0d val=%0d dly=%0d, expected kind=%0d val=%0d dly=%0d",
                         e.kind, kind, val, dly, e.kind, e.val, e.dly);
            end
        end
    endtask

    // Monitor: samples on the falling edge, pops and compares on each DUT event.
    initial begin
        logic [1:0] prev_gnt;
        logic [1:0] prev_done;
        prev_gnt  = '0;
        prev_done = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (mon_en) begin
                if (prev_done != 0) chk("gnt_low_after_done", int'(gnt), 0);
                if (gnt != 0 && prev_gnt == 0) begin
                    gnt_cyc = cyc;
                    expect_ev(0, int'(gnt), 0);
                end else if (gnt != 0 && prev_gnt != 0 && gnt != prev_gnt) begin
                    chk("gnt_back_to_back", int'(gnt), int'(prev_gnt));
                end
                if (step_pulse) begin
                    step_seen++;
                    expect_ev(1, int'(position), cyc - gnt_cyc);
                end
                if (done != 0) begin
                    done_seen++;
                    expect_ev(2, int'(done), cyc - gnt_cyc);
                    chk("gnt_during_done", int'(gnt), int'(done));
                end
            end
            prev_gnt  = gnt;
            prev_done = done;
        end
    end

    task automatic push_run(input int id, input bit d, input int n);
        ev_t e;
        e = '{0, 1 << id, 0};
        q.push_back(e);
        for (int k = 1; k <= n; k++) begin
            pos_m = (pos_m + (d ? 1 : 3)) % 4;
            e = '{1, pos_m, 4 * k};
            q.push_back(e);
        end
        e = '{2, 1 << id, (n == 0) ? 1 : 4 * n};
        q.push_back(e);
    endtask

    task automatic wait_done(input int target, input string name);
        int t;
        t = 0;
        while (done_seen < target && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (done_seen < target) chk(name, done_seen, target);
    endtask

    task automatic wait_steps(input int target, input string name);
        int t;
        t = 0;
        while (step_seen < target && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (step_seen < target) chk(name, step_seen, target);
    endtask

    // One full run by requester id; dir/steps are scrambled after grant.
    task automatic txn(input int id, input bit d, input int n, input string name);
        int t;
        int target;
        target = done_seen + 1;
        push_run(id, d, n);
        dir[id] = d;
        if (id == 0) steps0 = 4'(n); else steps1 = 4'(n);
        req[id] = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (gnt == 0 && t < 20);
        if (gnt == 0) chk({name, "_grant_timeout"}, 0, 1);
        else          chk({name, "_busy"}, int'(busy), 1);
        dir[id] = ~d;
        if (id == 0) steps0 = 4'd9; else steps1 = 4'd9;
        wait_done(target, {name, "_done_timeout"});
        req = '0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int target;
        ev_t e;

        // Power-up reset
        repeat (3) @(negedge clock);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_step", int'(step_pulse), 0);
        chk("rst_pos", int'(position), 0);
        reset = 1'b1;
        @(negedge clock);

        // Reset mid-run: get one step in, then pull reset for 2 cycles
        dir = 2'b01; steps0 = 4'd3; req = 2'b01;
        repeat (8) @(negedge clock);
        chk("pre_rst_pos_moved", int'(position), 1);
        reset = 1'b0;
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_step", int'(step_pulse), 0);
        chk("midrst_pos", int'(position), 0);
        @(negedge clock);
        mon_en = 1;

        txn(0, 1'b1, 3, "up3");      // 1,2,3
        txn(0, 1'b1, 1, "wrap_up");  // 3->0
        txn(1, 1'b0, 2, "down2");    // 0->3->2

        // Contested requests held: 01, 10, 01 with IDLE gaps
        target = done_seen + 3;
        push_run(0, 1'b1, 1);
        push_run(1, 1'b1, 1);
        push_run(0, 1'b1, 1);
        dir = 2'b11; steps0 = 4'd1; steps1 = 4'd1;
        req = 2'b11;
        wait_done(target, "rr_done_timeout");
        req = '0;
        repeat (2) @(negedge clock);

        txn(0, 1'b1, 0, "zero_steps");
        chk("zero_pos", int'(position), pos_m);

        // Drop req0 after two steps of a five-step run
        target = step_seen + 2;
`ifdef STEP_ABORT_EN
        e = '{0, 1, 0};
        q.push_back(e);
        pos_m = (pos_m + 1) % 4; e = '{1, pos_m, 4}; q.push_back(e);
        pos_m = (pos_m + 1) % 4; e = '{1, pos_m, 8}; q.push_back(e);
`else
        push_run(0, 1'b1, 5);
`endif
        dir = 2'b01; steps0 = 4'd5; req = 2'b01;
        wait_steps(target, "drop_step_timeout");
        req = '0;
`ifdef STEP_ABORT_EN
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        repeat (20) @(negedge clock);
`else
        wait_done(done_seen + 1, "drop_done_timeout");
        repeat (2) @(negedge clock);
`endif
        chk("drop_pos", int'(position), pos_m);
        chk("final_busy", int'(busy), 0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
